addsub_serial_ctrl: RTL

Sequencing controller for the calculator's add/subtract datapath. Accepts two unsigned operands and an opcode, then drives a single one-bit full-adder stage bit-serially, LSB first, one bit per clock. Subtraction is done in ones-complement: add the inverted B, then apply an end-around-carry pass. The result is presented as magnitude plus sign, ready for the display path, with a busy/done handshake toward the keypad/control FSM.

---
 rtl/addsub_serial_ctrl_pkg.sv | 21 ++
 rtl/addsub_serial_ctrl_fa_bit.sv | 35 +++
 rtl/addsub_serial_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding, opcode values and the bit-index width helper.
package addsub_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_EAC  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of the bit-index counter; never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/addsub_serial_ctrl_fa_bit.sv
// One-bit full-adder stage with a registered carry. The carry can be
// cleared (start of a pass) or advanced (one bit processed this cycle).
module serial_fa_bit (
  input  logic clk,
  input  logic rst,
  input  logic a_bit,
  input  logic b_bit,
  input  logic carry_en,
  input  logic carry_clr,
  output logic sum_bit,
  output logic carry
);

  logic carry_q;
  logic carry_d;
  logic cout;

  assign sum_bit = a_bit ^ b_bit ^ carry_q;
  assign cout    = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
  assign carry   = carry_q;

  // Next carry: clear wins over advance; otherwise hold.
  always_comb begin
    carry_d = carry_q;
    if (carry_clr)     carry_d = 1'b0;
    else if (carry_en) carry_d = cout;
  end

  // Carry register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) carry_q <= 1'b0;
    else      carry_q <= carry_d;
  end

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Bit-serial add/subtract sequencer. Operands are latched on an accepted
// start, processed LSB first through one full-adder stage, and subtraction
// uses ones-complement with an end-around-carry (+1) pass. Results are
// presented as magnitude plus sign together with a one-cycle done pulse.
//
// Handshake: start is only looked at while busy is low (IDLE). busy rises
// the cycle after the accepting edge and stays high through the done cycle
// (the FIN state); it drops the cycle after done, and a new start may be
// accepted in that very cycle. abort cancels any active operation with no
// done pulse and leaves sum/co/neg untouched.
module addsub_serial_ctrl
  import addsub_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             neg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             busy_q;

  logic             fa_a, fa_b;
  logic             fa_sum, fa_carry, fa_cout;
  logic             carry_en, carry_clr;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  serial_fa_bit u_fa (
    .clk       (clk),
    .rst       (rst),
    .a_bit     (fa_a),
    .b_bit     (fa_b),
    .carry_en  (carry_en),
    .carry_clr (carry_clr),
    .sum_bit   (fa_sum),
    .carry     (fa_carry)
  );

  // Carry out of the bit being processed this cycle.
  assign fa_cout  = (fa_a & fa_b) | (fa_carry & (fa_a ^ fa_b));
  // New sum bit enters at the MSB so the first (LSB) bit lands at bit 0.
  assign shifted  = {fa_sum, res_q[WIDTH-1:1]};
  assign last_bit = (idx_q == LAST_IDX);

  // Adder operand select: operands in ADD, result +1 (carry-in on bit 0) in EAC.
  always_comb begin
    fa_a = 1'b0;
    fa_b = 1'b0;
    case (state_q)
      ST_ADD: begin
        fa_a = a_sh_q[0];
        fa_b = b_sh_q[0];
      end
      ST_EAC: begin
        fa_a = res_q[0];
        fa_b = (idx_q == '0);
      end
      default: begin
        fa_a = 1'b0;
        fa_b = 1'b0;
      end
    endcase
  end

  // Next-state, datapath and output-formatting logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    co_d      = co_q;
    neg_d     = neg_q;
    carry_en  = 1'b0;
    carry_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          op_d      = op_sub;
          a_sh_d    = a;
          b_sh_d    = (op_sub == OP_SUB) ? ~b : b;
          idx_d     = '0;
          carry_clr = 1'b1;
          state_d   = ST_ADD;
        end
      end

      ST_ADD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          carry_en = 1'b1;
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          res_d    = shifted;
          if (last_bit) begin
            idx_d = '0;
            if (op_q == OP_SUB && fa_cout) begin
              // A > B: the ones-complement sum needs the end-around +1.
              carry_clr = 1'b1;
              state_d   = ST_EAC;
            end else begin
              state_d = ST_FIN;
              if (op_q == OP_ADD) begin
                sum_d = shifted;
                co_d  = fa_cout;
                neg_d = 1'b0;
              end else if (&shifted) begin
                // All-ones is negative zero (A == B): report plain zero.
                sum_d = '0;
                co_d  = 1'b0;
                neg_d = 1'b0;
              end else begin
                sum_d = ~shifted;
                co_d  = 1'b0;
                neg_d = 1'b1;
              end
            end
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end

      ST_EAC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          carry_en = 1'b1;
          res_d    = shifted;
          if (last_bit) begin
            // Final carry of the +1 pass is discarded.
            idx_d   = '0;
            state_d = ST_FIN;
            sum_d   = shifted;
            co_d    = 1'b0;
            neg_d   = 1'b0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_FIN);
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;
  assign neg  = neg_q;

endmodule
